// File: rtl/sqrt_arb_pkg.sv
// Shared types and round-robin helper for the sqrt_newton sharing arbiter.
// The picker is written for up to RR_MAX_REQ requesters and trimmed by the caller.
package sqrt_arb_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_ISSUE,
        ARB_WAIT,
        ARB_RESPOND
    } arb_state_t;

    localparam int RR_MAX_REQ = 32;
    localparam int RR_IDX_W   = 5;

    typedef struct packed {
        logic                found;
        logic [RR_IDX_W-1:0] idx;
    } rr_pick_t;

    // First set bit of valid at or after ptr, wrapping at n.
    function automatic rr_pick_t rr_pick(
        input logic [RR_MAX_REQ-1:0] valid,
        input logic [RR_IDX_W-1:0]   ptr,
        input int                    n
    );
        rr_pick_t            res;
        logic [RR_IDX_W:0]   k;
        res = '0;
        k   = '0;
        for (int i = 0; i < RR_MAX_REQ; i++) begin
            if (i < n && !res.found) begin
                k = {1'b0, ptr} + (RR_IDX_W + 1)'(i);
                if (k >= (RR_IDX_W + 1)'(n)) begin
                    k = k - (RR_IDX_W + 1)'(n);
                end
                if (valid[k[RR_IDX_W-1:0]]) begin
                    res.found = 1'b1;
                    res.idx   = k[RR_IDX_W-1:0];
                end
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/sqrt_share_arbiter_rr_pick.sv
// Combinational round-robin picker: one-hot grant plus binary index.
// The search starts at ptr_i and wraps at NUM_REQ.
module rr_pick_onehot
    import sqrt_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] valid_i,
    input  logic [IDX_W-1:0]   ptr_i,
    output logic               found_o,
    output logic [NUM_REQ-1:0] grant_o,
    output logic [IDX_W-1:0]   idx_o
);

    rr_pick_t pick;

    always_comb begin
        pick = rr_pick(RR_MAX_REQ'(valid_i), RR_IDX_W'(ptr_i), NUM_REQ);
    end

    assign found_o = pick.found;
    assign idx_o   = IDX_W'(pick.idx);
    assign grant_o = found_o ? (NUM_REQ'(1) << idx_o) : '0;

endmodule

// File: rtl/sqrt_share_arbiter.sv
// Round-robin sharing of one sqrt_newton unit between NUM_REQ requesters.
// One root in flight; a watchdog turns a hung unit into a timeout response.
module sqrt_share_arbiter
    import sqrt_arb_pkg::*;
#(
    parameter int DATA_WIDTH      = 32,
    parameter int FRACTIONAL_BITS = 16,
    parameter int NUM_REQ         = 4,
    parameter int TIMEOUT_CYCLES  = 256
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic [NUM_REQ-1:0]                  req_valid,
    input  logic [NUM_REQ-1:0][DATA_WIDTH-1:0]  req_x,
    output logic [NUM_REQ-1:0]                  req_ready,
    output logic [NUM_REQ-1:0]                  rsp_valid,
    output logic [DATA_WIDTH-1:0]               rsp_root,
    output logic                                rsp_timeout,
    output logic                                busy,
    output logic                                sqrt_start,
    output logic [DATA_WIDTH-1:0]               sqrt_x,
    input  logic                                sqrt_done,
    input  logic [DATA_WIDTH-1:0]               sqrt_root
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int TMR_W = $clog2(TIMEOUT_CYCLES);

    if (NUM_REQ < 2 || NUM_REQ > RR_MAX_REQ) begin : g_bad_num_req
        $error("sqrt_share_arbiter: NUM_REQ out of range");
    end
    if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
        $error("sqrt_share_arbiter: TIMEOUT_CYCLES must be >= 2");
    end
    if (FRACTIONAL_BITS < 0 || FRACTIONAL_BITS > DATA_WIDTH) begin : g_bad_fmt
        $error("sqrt_share_arbiter: FRACTIONAL_BITS exceeds DATA_WIDTH");
    end

    arb_state_t             state_q;
    logic [IDX_W-1:0]       rr_ptr_q;
    logic [IDX_W-1:0]       rr_ptr_d;
    logic [IDX_W-1:0]       grant_q;
    logic [DATA_WIDTH-1:0]  sqrt_x_q;
    logic [TMR_W-1:0]       timer_q;
    logic                   sqrt_start_q;
    logic [NUM_REQ-1:0]     rsp_valid_q;
    logic [DATA_WIDTH-1:0]  rsp_root_q;
    logic                   rsp_timeout_q;

    logic                   pick_found;
    logic [NUM_REQ-1:0]     pick_oh;
    logic [IDX_W-1:0]       pick_idx;

    rr_pick_onehot #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_pick (
        .valid_i (req_valid),
        .ptr_i   (rr_ptr_q),
        .found_o (pick_found),
        .grant_o (pick_oh),
        .idx_o   (pick_idx)
    );

    assign rr_ptr_d = (pick_idx == IDX_W'(NUM_REQ - 1))
                    ? '0 : pick_idx + IDX_W'(1);

    // Ready is gated by rst so every output reads 0 while reset is held.
    assign req_ready   = (state_q == ARB_IDLE && !rst) ? pick_oh : '0;
    assign busy        = (state_q != ARB_IDLE);
    assign sqrt_start  = sqrt_start_q;
    assign sqrt_x      = sqrt_x_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_root    = rsp_root_q;
    assign rsp_timeout = rsp_timeout_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ARB_IDLE;
            rr_ptr_q      <= '0;
            grant_q       <= '0;
            sqrt_x_q      <= '0;
            timer_q       <= '0;
            sqrt_start_q  <= 1'b0;
            rsp_valid_q   <= '0;
            rsp_root_q    <= '0;
            rsp_timeout_q <= 1'b0;
        end else begin
            unique case (state_q)
                ARB_IDLE: begin
                    if (pick_found) begin
                        grant_q      <= pick_idx;
                        sqrt_x_q     <= req_x[pick_idx];
                        rr_ptr_q     <= rr_ptr_d;
                        sqrt_start_q <= 1'b1;
                        state_q      <= ARB_ISSUE;
                    end
                end
                ARB_ISSUE: begin
                    sqrt_start_q <= 1'b0;
                    timer_q      <= '0;
                    state_q      <= ARB_WAIT;
                end
                ARB_WAIT: begin
                    timer_q <= timer_q + TMR_W'(1);
                    // A completion in the expiry cycle still counts as success.
                    if (sqrt_done) begin
                        rsp_valid_q   <= NUM_REQ'(1) << grant_q;
                        rsp_root_q    <= sqrt_root;
                        rsp_timeout_q <= 1'b0;
                        sqrt_x_q      <= '0;
                        state_q       <= ARB_RESPOND;
                    end else if (timer_q == TMR_W'(TIMEOUT_CYCLES - 1)) begin
                        rsp_valid_q   <= NUM_REQ'(1) << grant_q;
                        rsp_root_q    <= '0;
                        rsp_timeout_q <= 1'b1;
                        sqrt_x_q      <= '0;
                        state_q       <= ARB_RESPOND;
                    end
                end
                ARB_RESPOND: begin
                    rsp_valid_q   <= '0;
                    rsp_root_q    <= '0;
                    rsp_timeout_q <= 1'b0;
                    state_q       <= ARB_IDLE;
                end
                default: begin
                    state_q <= ARB_IDLE;
                end
            endcase
        end
    end

endmodule
